// File: rtl/audio_codec_pkg.sv
// ---------------------------------------------------------------------------
// audio_codec_pkg
// Shared constants and types for the serial audio codec interface.
//   SMPL_W     : parallel sample width
//   FRM_CNT_W  : width of the frame counter (1024 clk per stereo frame)
//   SCLK_RISE  : frm_cnt[4:0] value whose ending edge raises SCLK
//   SCLK_FALL  : frm_cnt[4:0] value whose ending edge lowers SCLK
//   LFT_LATCH  : frm_cnt value ending the left half of the frame
//   FRM_END    : frm_cnt value ending the whole frame
//   codec_state_e : codec reset / startup sequencing states
// ---------------------------------------------------------------------------
package audio_codec_pkg;

  localparam int SMPL_W    = 16;
  localparam int FRM_CNT_W = 10;

  localparam logic [4:0]           SCLK_RISE = 5'h0F;
  localparam logic [4:0]           SCLK_FALL = 5'h1F;
  localparam logic [FRM_CNT_W-1:0] LFT_LATCH = 10'h1FF;
  localparam logic [FRM_CNT_W-1:0] FRM_END   = 10'h3FF;

  typedef enum logic [1:0] {
    RST_CODEC = 2'd0,
    PRIME     = 2'd1,
    RUN       = 2'd2
  } codec_state_e;

endpackage

// File: rtl/codec_clk_gen.sv
// ---------------------------------------------------------------------------
// codec_clk_gen
// Free-running 10-bit frame counter and the codec clocks / strobes derived
// from it. SCLK and LRCLK are taken straight from counter bits so they are
// glitch-free register outputs.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   SCLK        : bit clock, clk/32 (frm_cnt[4])
//   LRCLK       : frame clock, clk/1024 (frm_cnt[9]); low = left
//   sclk_rise   : high in the cycle whose ending edge raises SCLK
//   sclk_fall   : high in the cycle whose ending edge lowers SCLK
//   frm_end     : high in the last cycle of the frame (frm_cnt == 0x3FF)
//   lft_latch   : high in the last cycle of the left half (frm_cnt == 0x1FF)
// ---------------------------------------------------------------------------
module codec_clk_gen
  import audio_codec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic SCLK,
  output logic LRCLK,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic frm_end,
  output logic lft_latch
);

  logic [FRM_CNT_W-1:0] frm_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_reg <= '0;
    end else begin
      frm_cnt_reg <= frm_cnt_reg + 1'b1;
    end
  end

  assign SCLK      = frm_cnt_reg[4];
  assign LRCLK     = frm_cnt_reg[FRM_CNT_W-1];
  assign sclk_rise = (frm_cnt_reg[4:0] == SCLK_RISE);
  assign sclk_fall = (frm_cnt_reg[4:0] == SCLK_FALL);
  assign frm_end   = (frm_cnt_reg == FRM_END);
  assign lft_latch = (frm_cnt_reg == LFT_LATCH);

endmodule

// File: rtl/audio_codec_intf.sv
// ---------------------------------------------------------------------------
// audio_codec_intf
// Serial audio front/back end: generates codec clocks, deserializes
// left-justified stereo samples from the ADC and serializes processed
// samples to the DAC, one stereo frame per 1024 clk.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   SDin       : serial data from codec ADC
//   lft_out    : left sample to transmit (sampled at frm_cnt == 0x3FF)
//   rght_out   : right sample to transmit (sampled at frm_cnt == 0x3FF)
//   SCLK       : bit clock, clk/32
//   LRCLK      : frame clock, clk/1024; low = left, high = right
//   SDout      : serial data to codec DAC
//   RSTn       : codec reset, active low
//   lft_in     : last received left sample
//   rght_in    : last received right sample
//   valid      : one-clk pulse when a new pair lands on lft_in/rght_in
// ---------------------------------------------------------------------------
module audio_codec_intf
  import audio_codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SDin,
  input  logic [SMPL_W-1:0] lft_out,
  input  logic [SMPL_W-1:0] rght_out,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDout,
  output logic              RSTn,
  output logic [SMPL_W-1:0] lft_in,
  output logic [SMPL_W-1:0] rght_in,
  output logic              valid
);

  logic sclk_rise;
  logic sclk_fall;
  logic frm_end;
  logic lft_latch;

  codec_clk_gen u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .frm_end   (frm_end),
    .lft_latch (lft_latch)
  );

  // -------------------------------------------------------------------------
  // Codec reset / startup sequencing
  // -------------------------------------------------------------------------
  codec_state_e state_reg;
  codec_state_e state_next;
  logic         valid_reg;
  logic         valid_next;
  logic         rstn_reg;
  logic         rstn_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RST_CODEC;
      valid_reg <= 1'b0;
      rstn_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      rstn_reg  <= rstn_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = 1'b0;
    rstn_next  = 1'b0;
    case (state_reg)
      RST_CODEC: if (frm_end) state_next = PRIME;
      PRIME:     if (frm_end) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = RST_CODEC;
    endcase
    // valid and RSTn are registered from the next state so they line up
    // with the frame wrap and cannot glitch while the state encoding moves.
    valid_next = frm_end && (state_next == RUN);
    rstn_next  = (state_next != RST_CODEC);
  end

  assign valid = valid_reg;
  assign RSTn  = rstn_reg;

  // -------------------------------------------------------------------------
  // Receive and transmit shifters
  // -------------------------------------------------------------------------
  logic [SMPL_W-1:0]   rx_shft_reg;
  logic [SMPL_W-1:0]   lft_hold_reg;
  logic [SMPL_W-1:0]   lft_in_reg;
  logic [SMPL_W-1:0]   rght_in_reg;
  logic [2*SMPL_W-1:0] tx_shft_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft_reg  <= '0;
      lft_hold_reg <= '0;
      lft_in_reg   <= '0;
      rght_in_reg  <= '0;
      tx_shft_reg  <= '0;
    end else begin
      if (sclk_rise) begin
        rx_shft_reg <= {rx_shft_reg[SMPL_W-2:0], SDin};
      end
      // Left word is parked until the right word completes so both
      // outputs change together on the frame boundary.
      if (lft_latch) begin
        lft_hold_reg <= rx_shft_reg;
      end
      if (frm_end) begin
        lft_in_reg  <= lft_hold_reg;
        rght_in_reg <= rx_shft_reg;
      end
      // frm_end coincides with an sclk_fall; the load must win so the
      // left MSB is on SDout from the LRCLK falling edge.
      if (frm_end) begin
        tx_shft_reg <= {lft_out, rght_out};
      end else if (sclk_fall) begin
        tx_shft_reg <= {tx_shft_reg[2*SMPL_W-2:0], 1'b0};
      end
    end
  end

  assign lft_in  = lft_in_reg;
  assign rght_in = rght_in_reg;
  assign SDout   = tx_shft_reg[2*SMPL_W-1];

endmodule

// File: tb/tb_audio_codec_intf.sv
// ---------------------------------------------------------------------------
// tb_audio_codec_intf
// Bench for audio_codec_intf. A codec model serializes per-frame words on
// SDin from the bench's own cycle count; a reference model predicts every
// output per cycle from frame arithmetic (position in frame, frame number).
// ---------------------------------------------------------------------------
module tb_audio_codec_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SDin = 1'b0;
  logic [15:0] lft_out = '0;
  logic [15:0] rght_out = '0;
  logic        SCLK;
  logic        LRCLK;
  logic        SDout;
  logic        RSTn;
  logic [15:0] lft_in;
  logic [15:0] rght_in;
  logic        valid;

  always #5 clk = ~clk;

  audio_codec_intf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SDin     (SDin),
    .lft_out  (lft_out),
    .rght_out (rght_out),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .SDout    (SDout),
    .RSTn     (RSTn),
    .lft_in   (lft_in),
    .rght_in  (rght_in),
    .valid    (valid)
  );

  typedef struct {
    logic [15:0] sd_l;
    logic [15:0] sd_r;
    logic [15:0] tx_l;
    logic [15:0] tx_r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t        vecs [4];
  int          errors = 0;
  int          checks = 0;
  int          c = 0;             // cycles since rst_n release
  int          first_valid = -1;
  int          random_mode = 0;
  int          chg_cyc = 0;
  logic [15:0] rx_l [16];
  logic [15:0] rx_r [16];
  logic [31:0] tx_w [16];         // word heard on SDout during frame f
  int          tbl_idx [16];
  logic [31:0] cap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_SCLK"},    32'(SCLK),    32'd0);
    check({tag, "_LRCLK"},   32'(LRCLK),   32'd0);
    check({tag, "_SDout"},   32'(SDout),   32'd0);
    check({tag, "_RSTn"},    32'(RSTn),    32'd0);
    check({tag, "_valid"},   32'(valid),   32'd0);
    check({tag, "_lft_in"},  32'(lft_in),  32'd0);
    check({tag, "_rght_in"}, 32'(rght_in), 32'd0);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      int          f;
      int          fc;
      logic [15:0] w;
      logic [31:0] tw;
      f  = c / 1024;
      fc = c % 1024;
      if (fc == 0) begin
        if (random_mode == 0) begin
          tbl_idx[f] = f % 4;
          rx_l[f]    = vecs[f % 4].sd_l;
          rx_r[f]    = vecs[f % 4].sd_r;
          lft_out    = vecs[f % 4].tx_l;
          rght_out   = vecs[f % 4].tx_r;
        end else begin
          tbl_idx[f] = -1;
          rx_l[f]    = 16'($urandom);
          rx_r[f]    = 16'($urandom);
          lft_out    = 16'($urandom);
          rght_out   = 16'($urandom);
          chg_cyc    = int'($urandom_range(1, 1022));
        end
        cap = '0;
      end
      // Mid-frame updates must only matter for the following frame.
      if (random_mode != 0 && fc == 'h200) lft_out = 16'($urandom);
      if (random_mode != 0 && fc == chg_cyc) rght_out = 16'($urandom);
      // Codec model: left-justified, MSB first, one bit per 32 clk.
      w    = (fc >= 512) ? rx_r[f] : rx_l[f];
      SDin = w[15 - ((fc % 512) / 32)];
      if (fc == 1023) tx_w[f + 1] = {lft_out, rght_out};

      check("SCLK",  32'(SCLK),  32'((c % 32) >= 16));
      check("LRCLK", 32'(LRCLK), 32'(fc >= 512));
      check("RSTn",  32'(RSTn),  32'(c >= 1024));
      check("valid", 32'(valid), 32'(c >= 2048 && fc == 0));
      tw = tx_w[f];
      check("SDout", 32'(SDout), 32'(tw[31 - fc / 32]));
      if (f == 0) begin
        check("lft_in_rst",  32'(lft_in),  32'd0);
        check("rght_in_rst", 32'(rght_in), 32'd0);
      end else if (f >= 2) begin
        check("lft_in",  32'(lft_in),  32'(rx_l[f - 1]));
        check("rght_in", 32'(rght_in), 32'(rx_r[f - 1]));
      end
      if (valid === 1'b1) begin
        $display("valid c=%0d lft_in=%h rght_in=%h", c, lft_in, rght_in);
        if (first_valid < 0) first_valid = c;
        if (f >= 1 && tbl_idx[f - 1] >= 0) begin
          check("tbl_lft_in",  32'(lft_in),  32'(vecs[tbl_idx[f - 1]].exp_l));
          check("tbl_rght_in", 32'(rght_in), 32'(vecs[tbl_idx[f - 1]].exp_r));
        end
      end
      // Reassemble SDout as the codec would, on SCLK rising edges.
      if (fc % 32 == 16) cap = {cap[30:0], SDout};
      if (fc == 1023) begin
        check("tx_frame", cap, tx_w[f]);
        if (f >= 1 && tbl_idx[f - 1] >= 0) check("tbl_tx_frame", cap, vecs[tbl_idx[f - 1]].exp_tx);
      end
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234, 32'h80017FFE};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 32'h0000FFFF};
    vecs[2] = '{16'h0001, 16'h8000, 16'h5555, 16'hAAAA, 16'h0001, 16'h8000, 32'h5555AAAA};
    vecs[3] = '{16'h7FFF, 16'hFFFE, 16'hFFFF, 16'h0001, 16'h7FFF, 16'hFFFE, 32'hFFFF0001};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Table-driven frames, then random frames, from a clean release
    c = 0;
    tx_w[0] = '0;
    first_valid = -1;
    random_mode = 0;
    rst_n = 1'b1;
    run_cycles(6 * 1024);
    check("first_valid_run1", 32'(first_valid), 32'd2048);
    random_mode = 1;
    run_cycles(4 * 1024 + 'h1A0);

    // Reset asserted mid-frame during RUN: outputs clear without a clock
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_now");
    repeat (3) @(negedge clk);
    check_all_zero("midrst_hold");

    // Restart: no valid before clock 2048, then one per frame
    c = 0;
    tx_w[0] = '0;
    first_valid = -1;
    rst_n = 1'b1;
    run_cycles(3 * 1024 + 64);
    check("first_valid_run2", 32'(first_valid), 32'd2048);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
